// File: rtl/instr_fetch.sv
// Fetch stage: issues word requests from the PC, queues returned words with their PCs,
// and hands them to decode one at a time. A redirect flushes everything and refetches.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectPc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [PW-1:0] qHead;
    logic [PW-1:0] qTail;
    logic [PW-1:0] pcqHead;
    logic [PW-1:0] pcqTail;
    logic [31:0]   qInstr [DEPTH];
    logic [31:0]   qPc    [DEPTH];
    logic [31:0]   pcqMem [DEPTH];

    logic [SW-1:0] occupancy;
    logic          grant;
    logic          respOk;
    logic          respDrop;
    logic          push;
    logic          pop;
    logic          unusedBits;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign unusedBits = ^redirectPc[1:0];

    assign instrValid = (count != '0);
    assign pop        = instrValid && instrReady;

    // A pop this cycle frees a slot immediately; without it DEPTH=2 cannot sustain one word per cycle.
    assign occupancy = SW'(outstanding) + SW'(drop) + SW'(count) - SW'(pop);
    assign imemReq   = rst_n && !redirect && (occupancy < DEPTH_S);
    assign imemAddr  = pc;
    assign grant     = imemReq && imemGnt;

    // A response with nothing in flight is a protocol violation and is ignored.
    assign respOk   = imemRvalid && ((outstanding != '0) || (drop != '0));
    assign respDrop = respOk && (drop != '0);
    assign push     = respOk && (drop == '0) && !redirect;

    assign instr   = instrValid ? qInstr[qHead] : '0;
    assign instrPc = instrValid ? qPc[qHead]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            qHead       <= '0;
            qTail       <= '0;
            pcqHead     <= '0;
            pcqTail     <= '0;
        end else if (redirect) begin
            pc          <= {redirectPc[31:2], 2'b00};
            count       <= '0;
            qHead       <= '0;
            qTail       <= '0;
            pcqHead     <= '0;
            pcqTail     <= '0;
            drop        <= drop + outstanding - CW'(respOk);
            outstanding <= '0;
        end else begin
            if (grant) begin
                pc      <= pc + 32'd4;
                pcqTail <= bump(pcqTail);
            end
            outstanding <= outstanding + CW'(grant) - CW'(push);
            if (respDrop) begin
                drop <= drop - CW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                qTail   <= bump(qTail);
                pcqHead <= bump(pcqHead);
            end
            if (pop) begin
                qHead <= bump(qHead);
            end
        end
    end

    // Payload storage carries no reset; validity is tracked entirely by the counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            qInstr[qTail] <= imemRdata;
            qPc[qTail]    <= pcqMem[pcqHead];
        end
        if (grant) begin
            pcqMem[pcqTail] <= pc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        imemRvalid |-> ((outstanding != '0) || (drop != '0)))
        else $error("instr_fetch: response with no request in flight");

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-programmable memory model feeds the DUT,
// expected decode-side PCs are queued on delivery and popped when decode consumes them.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectPc;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instr      (instr),
        .instrPc    (instrPc),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .redirect   (redirect),
        .redirectPc (redirectPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } resp_t;

    resp_t       pending[$];
    logic [31:0] expQ[$];
    logic [31:0] grantLog[$];
    logic [31:0] popLog[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          popCount = 0;
    int          grantCount = 0;
    logic [31:0] expPc = RESET_PC;
    bit          readyCmd = 1'b1;
    bit          redirCmd = 1'b0;
    logic [31:0] redirPcCmd = '0;
    bit          lastReq;
    bit          redirRespPop;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dataOf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic int liveCount();
        int n = 0;
        foreach (pending[i]) if (!pending[i].stale) n++;
        return n;
    endfunction

    task automatic tick();
        resp_t       r;
        bit          haveResp;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        haveResp = 1'b0;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            r = pending.pop_front();
            haveResp = 1'b1;
        end
        imemRvalid = haveResp;
        imemRdata  = haveResp ? dataOf(r.addr) : 32'hDEAD_BEEF;
        imemGnt    = 1'b1;
        instrReady = readyCmd;
        redirect   = redirCmd;
        redirectPc = redirPcCmd;
        redirCmd   = 1'b0;
        #1;
        checkVal("valid", instrValid, expQ.size() != 0);
        if (redirect) checkVal("req_in_redirect", imemReq, 1'b0);
        redirRespPop = redirect && haveResp && instrValid && instrReady;
        if (instrValid && instrReady && !redirect && expQ.size() != 0) begin
            e = expQ.pop_front();
            checkVal("instr_pc", instrPc, e);
            checkVal("instr", instr, dataOf(e));
            popLog.push_back(instrPc);
            popCount++;
        end
        if (imemReq && imemGnt) begin
            checkVal("addr", imemAddr, expPc);
            grantLog.push_back(imemAddr);
            pending.push_back('{addr: expPc, due: cyc + lat, stale: 1'b0});
            expPc = expPc + 32'd4;
            grantCount++;
        end
        if (redirect) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            expQ.delete();
            expPc = {redirectPc[31:2], 2'b00};
        end else if (haveResp && !r.stale && rst_n) begin
            expQ.push_back(r.addr);
        end
        checkVal("credit", (pending.size() + expQ.size()) <= DEPTH, 1'b1);
        lastReq = imemReq;
    endtask

    initial begin
        int g0;
        int p0;
        int n;
        rst_n      = 1'b0;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        instrReady = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_req", imemReq, 1'b0);
        checkVal("rst_valid", instrValid, 1'b0);
        checkVal("rst_instr", instr, 32'h0);
        checkVal("rst_pc", instrPc, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming from RESET_PC with single-cycle memory
        repeat (3) tick();
        checkVal("seq0", grantLog[0], 32'h100);
        checkVal("seq1", grantLog[1], 32'h104);
        checkVal("seq2", grantLog[2], 32'h108);
        p0 = popCount;
        repeat (8) tick();
        checkVal("throughput", popCount - p0, 8);

        // Decode stall
        readyCmd = 1'b0;
        g0 = grantCount;
        repeat (5) begin
            tick();
            checkVal("stall_head", instrPc, (expQ.size() != 0) ? expQ[0] : 32'hFFFF_FFFF);
        end
        checkVal("stall_grants", (grantCount - g0) <= DEPTH, 1'b1);
        checkVal("stall_req", lastReq, 1'b0);
        readyCmd = 1'b1;
        repeat (6) tick();

        // Latency 3, redirect with two requests in flight
        lat = 3;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n = liveCount();
            if (n == 2) break;
        end
        checkVal("fill_two", n, 2);
        redirCmd = 1'b1;
        redirPcCmd = 32'h0000_2002;
        grantLog.delete();
        popLog.delete();
        repeat (12) tick();
        checkVal("redir_addr", grantLog[0], 32'h2000);
        checkVal("redir_first_pc", popLog[0], 32'h2000);

        // Redirect coinciding with a response and a pop
        lat = 1;
        repeat (8) tick();
        redirCmd = 1'b1;
        redirPcCmd = 32'h0000_0500;
        tick();
        checkVal("redir_resp_pop", redirRespPop, 1'b1);
        tick();
        checkVal("redir_flush", instrValid, 1'b0);
        repeat (6) tick();

        // Back-to-back redirects
        lat = 2;
        repeat (4) tick();
        redirCmd = 1'b1;
        redirPcCmd = 32'h0000_3000;
        tick();
        redirCmd = 1'b1;
        redirPcCmd = 32'h0000_4006;
        grantLog.delete();
        popLog.delete();
        repeat (10) tick();
        checkVal("b2b_addr", grantLog[0], 32'h4004);
        checkVal("b2b_pc", popLog[0], 32'h4004);

        // Asynchronous reset with requests in flight
        lat = 3;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n = liveCount();
            if (n == 2) break;
        end
        checkVal("fill_rst", n, 2);
        #2 rst_n = 1'b0;
        #1;
        checkVal("arst_req", imemReq, 1'b0);
        checkVal("arst_valid", instrValid, 1'b0);
        checkVal("arst_instr", instr, 32'h0);
        checkVal("arst_pc", instrPc, 32'h0);
        foreach (pending[i]) pending[i].stale = 1'b1;
        expQ.delete();
        expPc = RESET_PC;
        repeat (8) tick();
        lat = 1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        grantLog.delete();
        popLog.delete();
        repeat (8) tick();
        checkVal("rst_restart", grantLog[0], 32'h100);
        checkVal("rst_first_pc", popLog[0], 32'h100);

        // PC wrap
        grantLog.delete();
        redirCmd = 1'b1;
        redirPcCmd = 32'hFFFF_FFFC;
        repeat (5) tick();
        checkVal("wrap0", grantLog[0], 32'hFFFF_FFFC);
        checkVal("wrap1", grantLog[1], 32'h0000_0000);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
